// File: rtl/barrel_pkg.sv
// Shared definitions for the sequential rotate/unrotate block: FSM states,
// rotate-direction encodings and the default data width.
package barrel_pkg;

   localparam int DEFAULT_WIDTH = 4;

   // Direction encodings: right rotate undoes a left-rotating barrel shifter
   localparam logic DIR_ROR = 1'b0;
   localparam logic DIR_ROL = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : barrel_pkg

// File: rtl/rotate1.sv
// Combinational single-bit rotate of a WIDTH-bit word, direction selectable.
module rotate1
   import barrel_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] data,
   input  logic             dir,
   output logic [WIDTH-1:0] data_out
);

   // Each output bit picks its wrap-around neighbour: the bit below for a left
   // rotate, the bit above for a right rotate, so no bit is ever lost.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         localparam int LEFT_SRC  = (gi + WIDTH - 1) % WIDTH;
         localparam int RIGHT_SRC = (gi + 1) % WIDTH;
         assign data_out[gi] = (dir == DIR_ROL) ? data[LEFT_SRC] : data[RIGHT_SRC];
      end
   endgenerate

endmodule : rotate1

// File: rtl/barrel_unshift_seq.sv
// Sequential rotator: accepts a word, rotates it one bit per clock by the
// requested amount, then holds the result until the consumer takes it.
module barrel_unshift_seq
   import barrel_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] DIN,
   input  logic [$clog2(WIDTH)-1:0] SEL,
   input  logic             DIR,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] DOUT,
   output logic             BUSY
);

   localparam int SEL_W = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [SEL_W-1:0]   cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic [WIDTH-1:0]   rot_data;

   rotate1 #(
      .WIDTH    (WIDTH)
   ) u_rotate1 (
      .data     (data_q),
      .dir      (dir_q),
      .data_out (rot_data)
   );

   // Next-state, datapath and handshake outputs derived from the next state
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      case (state_q)
         IDLE: begin
            if (IN_VALID) begin
               data_d  = DIN;
               cnt_d   = SEL;
               dir_d   = DIR;
               state_d = (SEL == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            data_d = rot_data;
            cnt_d  = cnt_q - SEL_W'(1);
            if (cnt_q == SEL_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (OUT_READY) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Outputs are registered so they change exactly on the state edge
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // State and output registers; reset wins over any handshake in the same cycle
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         data_q      <= '0;
         cnt_q       <= '0;
         dir_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         dir_q       <= dir_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = out_valid_q;
   assign BUSY      = busy_q;
   assign DOUT      = data_q;

endmodule : barrel_unshift_seq
